instr_fetch_unit: RTL and testbench

Instruction fetch unit that sits between the CPU controller and instruction memory. It owns the program counter (PC) and the instruction register (IR), and acts on the controller's loadIR / loadPC / incPC / selA strobes. It runs a req/ack read handshake to instruction memory and returns the fetched opcode to the controller. While a fetch is outstanding it raises `busy`, and it flags a memory timeout through a sticky `fault`.

---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR and fetches from instruction memory
// over a req/ack handshake, with a sticky timeout fault.
module instr_fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loadIR,
    input  logic               loadPC,
    input  logic               incPC,
    input  logic               selA,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [3:0]         opcode,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               ir_valid,
    output logic               fault
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [PC_W-1:0]    r_pc, r_addr;
    logic [INSTR_W-1:0] r_ir;
    logic               r_req, r_busy, r_valid, r_fault;
    logic               w_start, w_done, w_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        w_tmo   = 1'b0;
        case (r_state)
            S_IDLE, S_HOLD: begin
                if (loadIR) begin
                    w_next  = S_FETCH;
                    w_start = 1'b1;
                end
            end
            S_FETCH: begin
                // ack on the last allowed cycle still completes the fetch
                if (imem_ack) begin
                    w_next = S_HOLD;
                    w_done = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_IDLE;
                    w_tmo  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_ir    <= '0;
        end else if (w_start) begin
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (w_done) begin
            r_ir    <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
        end else if (w_tmo) begin
            r_fault <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
        end else if (r_state == S_FETCH) begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // PC moves only outside FETCH; a fetch launched this cycle uses the old PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (r_state != S_FETCH) begin
            if (loadPC && selA) r_pc <= r_ir[PC_W-1:0];
            else if (incPC)     r_pc <= r_pc + 1'b1;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign ir        = r_ir;
    assign opcode    = r_ir[INSTR_W-1 -: 4];
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign ir_valid  = r_valid;
    assign fault     = r_fault;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch, PC inc/wrap/jump, timeout, reset mid-fetch.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, loadIR, loadPC, incPC, selA, imem_ack;
    logic [15:0] imem_rdata;
    logic        imem_req, busy, ir_valid, fault;
    logic [7:0]  imem_addr, pc;
    logic [15:0] ir;
    logic [3:0]  opcode;
    int          n_chk = 0, n_err = 0;
    int          bcnt;

    instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .loadIR(loadIR), .loadPC(loadPC), .incPC(incPC),
        .selA(selA), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .opcode(opcode),
        .ir(ir), .pc(pc), .busy(busy), .ir_valid(ir_valid), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fetch with ack sampled on the second edge after the strobe
    task automatic fetch(input logic [15:0] d);
        loadIR = 1'b1; tick(); loadIR = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = d; tick(); imem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; loadIR = 0; loadPC = 0; incPC = 0; selA = 0;
        imem_ack = 0; imem_rdata = '0;
        tick(); tick();
        chk("rst_pc", pc, 0);           chk("rst_ir", ir, 0);
        chk("rst_opcode", opcode, 0);   chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);  chk("rst_busy", busy, 0);
        chk("rst_valid", ir_valid, 0);  chk("rst_fault", fault, 0);
        rst = 1'b0; tick();

        // basic fetch, ack sampled 3 edges after the strobe edge
        loadIR = 1'b1; tick(); loadIR = 1'b0;
        chk("bf_req", imem_req, 1); chk("bf_addr", imem_addr, 8'h00);
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 2; i++) begin tick(); bcnt += busy ? 1 : 0; end
        imem_ack = 1'b1; imem_rdata = 16'hB123; tick(); imem_ack = 1'b0;
        bcnt += busy ? 1 : 0;
        chk("bf_busy_cycles", bcnt, 3);
        chk("bf_ir", ir, 16'hB123);     chk("bf_opcode", opcode, 4'b1011);
        chk("bf_valid", ir_valid, 1);   chk("bf_req_low", imem_req, 0);
        chk("bf_pc", pc, 0);

        // increment and wrap: jump to 0xFE then two increments
        fetch(16'h00FE);
        loadPC = 1; selA = 1; tick(); loadPC = 0; selA = 0;
        chk("jmp_fe", pc, 8'hFE);
        incPC = 1; tick(); chk("inc_ff", pc, 8'hFF);
        tick(); incPC = 0; chk("inc_wrap", pc, 8'h00);

        // jump beats increment; loadPC without selA is a no-op
        fetch(16'hF042);
        chk("jp_opcode", opcode, 4'hF);
        loadPC = 1; selA = 1; incPC = 1; tick(); incPC = 0; selA = 0;
        chk("jmp_prio", pc, 8'h42);
        tick(); loadPC = 0;
        chk("ldpc_nosel", pc, 8'h42);

        // fetch with incPC: fetch at old PC, PC increments in parallel
        loadIR = 1; incPC = 1; tick(); loadIR = 0; incPC = 0;
        chk("fi_addr", imem_addr, 8'h42); chk("fi_pc", pc, 8'h43);
        chk("fi_valid_clr", ir_valid, 0);
        imem_ack = 1; imem_rdata = 16'h1234; tick(); imem_ack = 0;
        chk("fi_ir", ir, 16'h1234);

        // strobes ignored in FETCH; stray ack in HOLD ignored
        loadIR = 1; tick(); loadIR = 0;
        loadPC = 1; selA = 1; incPC = 1; loadIR = 1; tick();
        loadPC = 0; selA = 0; incPC = 0; loadIR = 0;
        chk("fs_pc", pc, 8'h43); chk("fs_addr", imem_addr, 8'h43);
        imem_ack = 1; imem_rdata = 16'h5A5A; tick();
        chk("fs_ir", ir, 16'h5A5A);
        imem_rdata = 16'hFFFF; tick(); imem_ack = 0;
        chk("stray_ir", ir, 16'h5A5A); chk("stray_req", imem_req, 0);
        chk("stray_valid", ir_valid, 1); chk("stray_pc", pc, 8'h43);

        // timeout: no ack for 16 FETCH cycles
        loadIR = 1; tick(); loadIR = 0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_req_c15", imem_req, 1); chk("to_fault_c15", fault, 0);
        tick();
        chk("to_req", imem_req, 0);   chk("to_fault", fault, 1);
        chk("to_busy", busy, 0);      chk("to_valid", ir_valid, 0);
        chk("to_ir", ir, 16'h5A5A);
        imem_ack = 1; imem_rdata = 16'h7777; tick(); imem_ack = 0;
        chk("to_idle_ack_ir", ir, 16'h5A5A);
        fetch(16'h2345);
        chk("to_sticky", fault, 1); chk("to_refetch_ir", ir, 16'h2345);

        // reset in second FETCH cycle acts before the next edge
        loadIR = 1; tick(); loadIR = 0;
        tick();
        chk("rm_busy_pre", busy, 1);
        rst = 1; #1;
        chk("rm_req", imem_req, 0); chk("rm_busy", busy, 0);
        chk("rm_pc", pc, 0);        chk("rm_fault", fault, 0);
        tick(); rst = 0; tick();

        // ack on the last allowed FETCH cycle wins
        loadIR = 1; tick(); loadIR = 0;
        for (int i = 0; i < 15; i++) tick();
        imem_ack = 1; imem_rdata = 16'hC0DE; tick(); imem_ack = 0;
        chk("ack16_fault", fault, 0); chk("ack16_ir", ir, 16'hC0DE);
        chk("ack16_valid", ir_valid, 1); chk("ack16_req", imem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
